// File: rtl/prio_rr_arbiter.sv
// 8-way request arbiter: fixed-priority or round-robin winner, registered grant with hold budget.
// Latency: req sampled at a rising edge appears as gnt right after that same edge (1 cycle).
// Backpressure: none; the owner releases by dropping req, or loses the grant when its budget runs out.
module prio_rr_arbiter #(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             mode_rr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    // hold_cnt needs to reach MAX_HOLD; with no limit the counter is unused and kept at zero
    localparam int HC_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HC_W-1:0] HOLD_SAT = (MAX_HOLD > 0) ? HC_W'(MAX_HOLD) : '0;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  owner, owner_nxt;
    logic [IDX_W-1:0]  ptr, ptr_nxt;
    logic [HC_W-1:0]   hold_cnt, hold_nxt;
    logic              new_gnt;
    logic [IDX_W-1:0]  win;
    logic [N-1:0]      others;
    logic              timeout;
    logic [N-1:0]      gnt_nxt;
    logic [IDX_W-1:0]  idx_nxt;
    logic              valid_nxt;

    // Priority search: fixed mode takes the highest set index; RR mode walks
    // downward from start, wrapping 0 -> N-1 through unsigned index arithmetic.
    function automatic logic [IDX_W-1:0] pick(input logic [N-1:0] v,
                                              input logic [IDX_W-1:0] start,
                                              input logic rr);
        logic [IDX_W-1:0] w;
        logic [IDX_W-1:0] cand;
        logic             found;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = rr ? (start - IDX_W'(k)) : IDX_W'(N - 1 - k);
            if (!found && v[cand]) begin
                w     = cand;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign others = req & ~(N'(1) << owner);
    // ">=" rather than "==" so a saturated counter still yields once a competitor shows up
    assign timeout = (MAX_HOLD > 0) && (int'(hold_cnt) >= MAX_HOLD - 1);

    // State, owner, pointer, hold counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            ptr       <= '1;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_nxt;
            gnt       <= gnt_nxt;
            gnt_idx   <= idx_nxt;
            gnt_valid <= valid_nxt;
        end
    end

    // Next-state: decide on release, timeout hand-over or hold; a new grant rotates ptr
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        new_gnt   = 1'b0;
        win       = '0;
        case (state)
            IDLE: begin
                if (|req) begin
                    new_gnt   = 1'b1;
                    win       = pick(req, ptr, mode_rr);
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!req[owner]) begin
                    // release (also covers drop coinciding with timeout): hand over with no bubble
                    if (|req) begin
                        new_gnt = 1'b1;
                        win     = pick(req, ptr, mode_rr);
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (timeout && (|others)) begin
                    // budget spent: owner sits out this one search only
                    new_gnt = 1'b1;
                    win     = pick(others, ptr, mode_rr);
                end else if (hold_cnt != HOLD_SAT) begin
                    hold_nxt = hold_cnt + HC_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (new_gnt) begin
            owner_nxt = win;
            ptr_nxt   = win - IDX_W'(1);
            hold_nxt  = '0;
        end
    end

    // Output decode of the next state, registered alongside it
    always_comb begin
        gnt_nxt   = '0;
        idx_nxt   = '0;
        valid_nxt = 1'b0;
        if (state_nxt == GRANT) begin
            gnt_nxt   = N'(1) << owner_nxt;
            idx_nxt   = owner_nxt;
            valid_nxt = 1'b1;
        end
    end

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Directed and random checks for prio_rr_arbiter built with a 4-cycle hold budget.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that point.
// Random phase tracks per-requester waiting time in round-robin mode.
module tb_prio_rr_arbiter;

    localparam int MAXH  = 4;
    localparam int STARV = 7 * MAXH + 7;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       mode_rr;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int errors = 0;
    int checks = 0;

    prio_rr_arbiter #(.N(8), .IDX_W(3), .MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mode_rr   (mode_rr),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int wait_cnt [8];
    logic [7:0] req_prev;
    logic       mode_prev;
    int         exp_idx;

    initial begin
        rst     = 1'b1;
        req     = 8'hFF;
        mode_rr = 1'b0;

        // 1: reset holds grant off, then highest requester wins
        step();
        step();
        chk("rst_gnt",   32'(gnt), 32'h00);
        chk("rst_valid", 32'(gnt_valid), 32'd0);
        chk("rst_idx",   32'(gnt_idx), 32'd0);
        rst = 1'b0;
        step();
        chk("t1_gnt", 32'(gnt), 32'h80);
        chk("t1_idx", 32'(gnt_idx), 32'd7);

        // 2: fixed priority, hand-over without bubble, then idle
        req = 8'h05;
        step();
        chk("t2_gnt_a", 32'(gnt), 32'h04);
        step();
        chk("t2_gnt_hold", 32'(gnt), 32'h04);
        req = 8'h01;
        step();
        chk("t2_gnt_b", 32'(gnt), 32'h01);
        chk("t2_idx_b", 32'(gnt_idx), 32'd0);
        req = 8'h00;
        step();
        chk("t2_valid_off", 32'(gnt_valid), 32'd0);
        chk("t2_gnt_off",   32'(gnt), 32'h00);

        // 3: round-robin rotation, each owner drops after one cycle
        mode_rr = 1'b1;
        req = 8'hFF;
        step();
        chk("t3_first", 32'(gnt_idx), 32'd7);
        for (int k = 1; k <= 8; k++) begin
            req = ~gnt;
            step();
            exp_idx = (7 - k) & 7;
            chk($sformatf("t3_seq%0d", k), 32'(gnt_idx), 32'(exp_idx));
            chk($sformatf("t3_gnt%0d", k), 32'(gnt), 32'h1 << exp_idx);
        end
        req = 8'h00;
        step();
        chk("t3_idle", 32'(gnt_valid), 32'd0);

        // 4: hold budget alternates two steady requesters; lone requester keeps it
        mode_rr = 1'b0;
        req = 8'h81;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("t4_a%0d", k), 32'(gnt_idx), 32'd7);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("t4_b%0d", k), 32'(gnt_idx), 32'd0);
        end
        step();
        chk("t4_c", 32'(gnt_idx), 32'd7);
        req = 8'h80;
        for (int k = 0; k < 20; k++) begin
            step();
            chk($sformatf("t4_solo%0d", k), 32'(gnt), 32'h80);
        end

        // 5: reset mid-grant drops grant and restores the RR pointer
        req = 8'h00;
        step();
        mode_rr = 1'b1;
        req = 8'h10;
        step();
        chk("t5_pre", 32'(gnt), 32'h10);
        rst = 1'b1;
        req = 8'h11;
        step();
        chk("t5_rst_gnt",   32'(gnt), 32'h00);
        chk("t5_rst_valid", 32'(gnt_valid), 32'd0);
        rst = 1'b0;
        step();
        chk("t5_ptr_idx", 32'(gnt_idx), 32'd4);

        // 6: random sticky requests; invariants and RR starvation bound
        for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 15) == 0) req[i] = ~req[i];
            if ($urandom_range(0, 199) == 0) mode_rr = ~mode_rr;
            req_prev  = req;
            mode_prev = mode_rr;
            step();
            chk("r_onehot", 32'($onehot0(gnt)), 32'd1);
            chk("r_valid",  32'(gnt_valid), 32'(|gnt));
            chk("r_idx",    32'(gnt), gnt_valid ? (32'h1 << gnt_idx) : 32'h0);
            if (!gnt_valid) chk("r_idx0", 32'(gnt_idx), 32'd0);
            for (int i = 0; i < 8; i++) begin
                if (mode_prev && req_prev[i] && !gnt[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (wait_cnt[i] > STARV) begin
                    chk($sformatf("r_starve%0d", i), 32'(wait_cnt[i]), 32'(STARV));
                    wait_cnt[i] = 0;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
